// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD      = 9600;
  // Rounded to the nearest cycle (10417 at the defaults) to keep bit-cell error minimal.
  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; reset value is a parameter.
// Latency: 2 core_clk cycles from async_dat to sync_dat.
// Backpressure: none, free-running.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic async_dat,
  output logic sync_dat
);

  logic meta_q;

  // Two back-to-back flops resolve metastability before the level is used.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q   <= RST_VAL;
      sync_dat <= RST_VAL;
    end else begin
      meta_q   <= async_dat;
      sync_dat <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with mid-bit sampling and a CPU-facing holding register plus sticky flags.
// Latency: rx_valid rises HALF_BIT + 9*CLKS_PER_BIT + 3 cycles after the start-bit falling edge.
// Backpressure: none; an unacknowledged byte is overwritten by the next one and overrun is flagged.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                           sysclk,
  input  logic                           reset,
  input  logic                           UART_RX,
  input  logic                           rd_ack,
  output logic [uart_pkg::DATA_BITS-1:0] rx_data,
  output logic                           rx_valid,
  output logic                           overrun,
  output logic                           frame_err,
  output logic                           rx_busy
);

  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

  // Bring the idle-high serial pin into the sysclk domain.
  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .core_clk  (sysclk),
    .arst_n    (reset),
    .async_dat (UART_RX),
    .sync_dat  (rx_s)
  );

  assign rx_busy = (state != IDLE);

  // Frame state machine, baud counter and CPU-visible holding register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Ack clears the flags; a byte load or framing error below overrides this.
      if (rd_ack) begin
        rx_valid  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line back high at mid start bit is a glitch, not a frame.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (rx_valid && !rd_ack) begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot start a phantom frame.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
